// File: rtl/iadc_ctrl_sequencer.sv
// iadc_ctrl_sequencer: iADC clock bring-up sequencer and 3-wire control serialiser
module iadc_ctrl_sequencer #(
  parameter int CLK_DIV        = 4,
  parameter int DCM_RST_CYCLES = 16,
  parameter int DDRB_CYCLES    = 8,
  parameter int LOCK_TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_lock,
  input  logic        cfg_mode,
  input  logic        wr_req,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  input  logic        ddrb_req,
  output logic        busy,
  output logic        init_done,
  output logic        lock_fail,
  output logic        adc_dcm_reset,
  output logic        adc_ddrb,
  output logic        adc_ctrl_clk,
  output logic        adc_ctrl_data,
  output logic        adc_ctrl_strobe_n,
  output logic        adc_mode
);
  localparam int MX = (CLK_DIV > DCM_RST_CYCLES) ? ((CLK_DIV > DDRB_CYCLES) ? CLK_DIV : DDRB_CYCLES)
                                                 : ((DCM_RST_CYCLES > DDRB_CYCLES) ? DCM_RST_CYCLES : DDRB_CYCLES);
  localparam int CW = $clog2(MX + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  typedef enum logic [2:0] {INIT_RST, WAIT_LOCK, DDRB_INIT, IDLE, DDRB_MAN, SHIFT, HOLD, GAP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [LW-1:0] lock_cnt, lock_cnt_nx;
  logic [4:0] bit_cnt, bit_cnt_nx;
  logic [17:0] sh, sh_nx;
  logic [1:0] sync;
  logic lock_s, ph, ph_nx, data_nx, strobe_nx, clk_nx, ack_nx, done_nx, fail_nx, div_end;
  assign lock_s  = sync[1];
  assign div_end = cnt == CW'(CLK_DIV - 1);
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt + 1'b1;
    lock_cnt_nx = '0;
    bit_cnt_nx  = bit_cnt;
    ph_nx       = ph;
    sh_nx       = sh;
    data_nx     = adc_ctrl_data;
    strobe_nx   = adc_ctrl_strobe_n;
    clk_nx      = 1'b0;
    ack_nx      = 1'b0;
    fail_nx     = lock_fail;
    done_nx     = (state inside {DDRB_MAN, SHIFT, HOLD, GAP}) ? init_done & lock_s : init_done;
    case (state)
      INIT_RST: if (cnt == CW'(DCM_RST_CYCLES - 1)) begin
        state_nx = WAIT_LOCK;
        cnt_nx   = '0;
      end
      WAIT_LOCK: begin
        cnt_nx      = '0;
        lock_cnt_nx = lock_cnt + 1'b1;
        if (lock_s) state_nx = DDRB_INIT;
        else if (lock_cnt == LW'(LOCK_TIMEOUT - 1)) begin
          state_nx = INIT_RST;
          fail_nx  = 1'b1;
        end
      end
      DDRB_INIT, DDRB_MAN: if (cnt == CW'(DDRB_CYCLES - 1)) begin
        cnt_nx   = '0;
        done_nx  = (state == DDRB_INIT) | done_nx;
        fail_nx  = (state == DDRB_INIT) ? 1'b0 : lock_fail;
        state_nx = done_nx ? IDLE : INIT_RST;
      end
      IDLE: begin
        cnt_nx = '0;
        if (!lock_s) begin
          state_nx = INIT_RST;
          done_nx  = 1'b0;
        end else if (ddrb_req) state_nx = DDRB_MAN;
        else if (wr_req) begin
          state_nx   = SHIFT;
          sh_nx      = {wr_addr[1:0], wr_data};
          data_nx    = wr_addr[2];
          strobe_nx  = 1'b0;
          ack_nx     = 1'b1;
          bit_cnt_nx = 5'd18;
          ph_nx      = 1'b0;
        end
      end
      SHIFT: begin
        clk_nx = div_end ? ~ph : ph;
        if (div_end) begin
          cnt_nx = '0;
          ph_nx  = ~ph;
          // Data only advances at the falling edge so the ADC sees it stable on the rise
          if (ph && bit_cnt == 5'd0) state_nx = HOLD;
          else if (ph) begin
            bit_cnt_nx = bit_cnt - 1'b1;
            data_nx    = sh[17];
            sh_nx      = {sh[16:0], 1'b0};
          end
        end
      end
      HOLD: if (div_end) begin
        cnt_nx    = '0;
        state_nx  = GAP;
        strobe_nx = 1'b1;
        data_nx   = 1'b0;
      end
      GAP: if (div_end) begin
        cnt_nx   = '0;
        state_nx = done_nx ? IDLE : INIT_RST;
      end
      default: state_nx = INIT_RST;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= INIT_RST;
      cnt               <= '0;
      lock_cnt          <= '0;
      bit_cnt           <= '0;
      ph                <= 1'b0;
      sh                <= '0;
      sync              <= '0;
      adc_dcm_reset     <= 1'b1;
      adc_ddrb          <= 1'b0;
      adc_ctrl_clk      <= 1'b0;
      adc_ctrl_data     <= 1'b0;
      adc_ctrl_strobe_n <= 1'b1;
      adc_mode          <= 1'b0;
      wr_ack            <= 1'b0;
      busy              <= 1'b1;
      init_done         <= 1'b0;
      lock_fail         <= 1'b0;
    end else begin
      state             <= state_nx;
      cnt               <= cnt_nx;
      lock_cnt          <= lock_cnt_nx;
      bit_cnt           <= bit_cnt_nx;
      ph                <= ph_nx;
      sh                <= sh_nx;
      sync              <= {sync[0], clk_lock};
      adc_dcm_reset     <= state_nx == INIT_RST;
      adc_ddrb          <= state_nx == DDRB_INIT || state_nx == DDRB_MAN;
      adc_ctrl_clk      <= clk_nx;
      adc_ctrl_data     <= data_nx;
      adc_ctrl_strobe_n <= strobe_nx;
      adc_mode          <= cfg_mode;
      wr_ack            <= ack_nx;
      busy              <= state_nx != IDLE;
      init_done         <= done_nx;
      lock_fail         <= fail_nx;
    end
  end
endmodule

// File: tb/tb_iadc_ctrl_sequencer.sv
// tb_iadc_ctrl_sequencer: directed checks of bring-up, serial writes, DDRB requests and lock loss
module tb_iadc_ctrl_sequencer;
  logic clk = 0, reset = 1, clk_lock = 1, cfg_mode = 0, wr_req = 0, ddrb_req = 0;
  logic [2:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic wr_ack, busy, init_done, lock_fail, adc_dcm_reset, adc_ddrb;
  logic adc_ctrl_clk, adc_ctrl_data, adc_ctrl_strobe_n, adc_mode;
  int total = 0, bad = 0;
  int acks, first_ack, ddrb_n, ddrb_last, stb_low, stb_rise, busy_n, nbits, fall, dcm_first, n;
  logic [18:0] bits;
  iadc_ctrl_sequencer #(.CLK_DIV(2), .DCM_RST_CYCLES(16), .DDRB_CYCLES(8), .LOCK_TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .clk_lock(clk_lock), .cfg_mode(cfg_mode),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .ddrb_req(ddrb_req), .busy(busy), .init_done(init_done), .lock_fail(lock_fail),
    .adc_dcm_reset(adc_dcm_reset), .adc_ddrb(adc_ddrb), .adc_ctrl_clk(adc_ctrl_clk),
    .adc_ctrl_data(adc_ctrl_data), .adc_ctrl_strobe_n(adc_ctrl_strobe_n), .adc_mode(adc_mode)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic observe(input int ncyc, input int drop_at);
    logic pclk;
    acks = 0; first_ack = -1; ddrb_n = 0; ddrb_last = -1; stb_low = 0; stb_rise = -1;
    busy_n = 0; nbits = 0; bits = '0; fall = -1; dcm_first = -1;
    pclk = adc_ctrl_clk;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (i == 1) ddrb_req = 0;
      if (i == drop_at) clk_lock = 0;
      if (wr_ack) begin acks++; if (first_ack < 0) first_ack = i; wr_req = 0; end
      if (adc_ddrb) begin ddrb_n++; ddrb_last = i; end
      if (!adc_ctrl_strobe_n) stb_low++;
      else if (stb_low > 0 && stb_rise < 0) stb_rise = i;
      if (busy) busy_n++;
      if (adc_ctrl_clk && !pclk) begin bits = {bits[17:0], adc_ctrl_data}; nbits++; end
      pclk = adc_ctrl_clk;
      if (!init_done && fall < 0) fall = i;
      if (adc_dcm_reset && dcm_first < 0) dcm_first = i;
    end
  endtask
  task automatic wait_done();
    n = 0;
    while (!init_done && n < 400) begin @(negedge clk); n++; end
    chk("init_done_wait", init_done, 1);
    @(negedge clk);
  endtask
  initial begin
    cfg_mode = 1;
    repeat (3) @(negedge clk);
    chk("rst_dcm", adc_dcm_reset, 1);
    chk("rst_outs", {adc_ddrb, adc_ctrl_clk, adc_ctrl_data, adc_ctrl_strobe_n, adc_mode}, 5'b00010);
    chk("rst_flags", {wr_ack, busy, init_done, lock_fail}, 4'b0100);
    reset = 0;
    n = 0;
    while (adc_dcm_reset && n < 100) begin n++; @(negedge clk); end
    chk("init_dcm_len", n, 16);
    chk("mode_follow", adc_mode, 1);
    n = 0;
    while (!adc_ddrb && n < 20) begin n++; @(negedge clk); end
    chk("init_sync_gap", n >= 1 && n <= 3, 1);
    n = 0;
    while (adc_ddrb && n < 50) begin n++; @(negedge clk); end
    chk("init_ddrb_len", n, 8);
    chk("init_done_busy", {init_done, busy, lock_fail}, 3'b100);
    wr_addr = 3'b101; wr_data = 16'hA5C3; wr_req = 1;
    observe(120, -1);
    chk("w1_ack", acks, 1);
    chk("w1_ack_at", first_ack, 1);
    chk("w1_bits", bits, 19'b101_1010010111000011);
    chk("w1_nbits", nbits, 19);
    chk("w1_stb_low", stb_low, 78);
    chk("w1_stb_rise", stb_rise, 79);
    chk("w1_busy", busy_n, 80);
    wr_addr = 3'b010; wr_data = 16'h1234; wr_req = 1; ddrb_req = 1;
    observe(150, -1);
    chk("w2_ddrb_len", ddrb_n, 8);
    chk("w2_ddrb_last", ddrb_last, 8);
    chk("w2_ack", acks, 1);
    chk("w2_ack_at", first_ack, 10);
    chk("w2_bits", bits, {3'b010, 16'h1234});
    chk("w2_stb_rise", stb_rise, 88);
    chk("w2_busy", busy_n, 88);
    clk_lock = 0; reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    n = 0;
    while (!lock_fail && n < 300) begin @(negedge clk); n++; end
    chk("to_fail_at", n, 116);
    n = 0;
    while (adc_dcm_reset && n < 100) begin n++; @(negedge clk); end
    chk("to_dcm_len", n, 16);
    chk("to_fail_sticky", lock_fail, 1);
    clk_lock = 1;
    wait_done();
    chk("to_fail_clr", lock_fail, 0);
    wr_addr = 3'b111; wr_data = 16'h0F0F; wr_req = 1;
    observe(100, 20);
    chk("ll_bits", bits, {3'b111, 16'h0F0F});
    chk("ll_stb_rise", stb_rise, 79);
    chk("ll_fall_lat", fall >= 21 && fall <= 23, 1);
    chk("ll_dcm_at", dcm_first, 81);
    clk_lock = 1;
    wait_done();
    wr_addr = 3'b011; wr_data = 16'hBEEF; wr_req = 1;
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      if (wr_ack) wr_req = 0;
    end
    chk("mid_stb_low", adc_ctrl_strobe_n, 0);
    reset = 1;
    @(negedge clk);
    chk("mid_rst", {adc_ctrl_strobe_n, adc_ctrl_clk, adc_dcm_reset, wr_ack}, 4'b1010);
    reset = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
